// File: rtl/alu_ctrl_pkg.sv
// Shared encodings and the issue-entry record for the ALU issue stage.
package alu_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LLI   = 6'b011000;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_NAND = 6'b101000;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SHT  = 6'b101100;
  localparam logic [5:0] FN_SHTU = 6'b101101;

  localparam int ALU_LLI_BIT  = 15;
  localparam int ALU_NAND_BIT = 14;
  localparam int ALU_SHTU_BIT = 13;
  localparam int ALU_SHT_BIT  = 12;
  localparam int ALU_ADD_BIT  = 11;
  localparam int ALU_SUB_BIT  = 10;
  localparam int ALU_SLT_BIT  = 9;
  localparam int ALU_SLTU_BIT = 8;
  localparam int ALU_AND_BIT  = 7;
  localparam int ALU_NOR_BIT  = 6;
  localparam int ALU_OR_BIT   = 5;
  localparam int ALU_XOR_BIT  = 4;
  localparam int ALU_SLL_BIT  = 3;
  localparam int ALU_SRL_BIT  = 2;
  localparam int ALU_SRA_BIT  = 1;
  localparam int ALU_LUI_BIT  = 0;

  typedef struct packed {
    logic [15:0] control;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  wdest;
    logic        illegal;
  } issue_t;

  function automatic logic [15:0] onehot(input int bit_idx);
    return 16'(1) << bit_idx;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decode of one instruction and its register operands into an issue entry.
module alu_op_decode
  import alu_ctrl_pkg::*;
(
  input  logic [31:0] inst,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output issue_t      dec
);

  logic [5:0]  op;
  logic [5:0]  fn;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] shamt;

  assign op    = inst[31:26];
  assign fn    = inst[5:0];
  assign imm_s = {{16{inst[15]}}, inst[15:0]};
  assign imm_z = {16'd0, inst[15:0]};
  assign shamt = {27'd0, inst[10:6]};

  // NOTE: every field gets a default before the case so no path can infer a latch.
  always_comb begin
    dec = '0;
    if (op == OP_RTYPE) begin
      dec.src1  = rs_value;
      dec.src2  = rt_value;
      dec.wdest = inst[15:11];
      case (fn)
        FN_SLL:          begin dec.control = onehot(ALU_SLL_BIT); dec.src1 = shamt; end
        FN_SRL:          begin dec.control = onehot(ALU_SRL_BIT); dec.src1 = shamt; end
        FN_SRA:          begin dec.control = onehot(ALU_SRA_BIT); dec.src1 = shamt; end
        FN_SLLV:         dec.control = onehot(ALU_SLL_BIT);
        FN_SRLV:         dec.control = onehot(ALU_SRL_BIT);
        FN_SRAV:         dec.control = onehot(ALU_SRA_BIT);
        FN_ADD, FN_ADDU: dec.control = onehot(ALU_ADD_BIT);
        FN_SUB, FN_SUBU: dec.control = onehot(ALU_SUB_BIT);
        FN_AND:          dec.control = onehot(ALU_AND_BIT);
        FN_OR:           dec.control = onehot(ALU_OR_BIT);
        FN_XOR:          dec.control = onehot(ALU_XOR_BIT);
        FN_NOR:          dec.control = onehot(ALU_NOR_BIT);
        FN_NAND:         dec.control = onehot(ALU_NAND_BIT);
        FN_SLT:          dec.control = onehot(ALU_SLT_BIT);
        FN_SLTU:         dec.control = onehot(ALU_SLTU_BIT);
        FN_SHT:          dec.control = onehot(ALU_SHT_BIT);
        FN_SHTU:         dec.control = onehot(ALU_SHTU_BIT);
        default:         dec.illegal = 1'b1;
      endcase
    end else begin
      dec.src1  = rs_value;
      dec.src2  = imm_z;
      dec.wdest = inst[20:16];
      case (op)
        OP_ADDIU: begin dec.control = onehot(ALU_ADD_BIT);  dec.src2 = imm_s; end
        OP_SLTI:  begin dec.control = onehot(ALU_SLT_BIT);  dec.src2 = imm_s; end
        OP_SLTIU: begin dec.control = onehot(ALU_SLTU_BIT); dec.src2 = imm_s; end
        OP_ANDI:  dec.control = onehot(ALU_AND_BIT);
        OP_ORI:   dec.control = onehot(ALU_OR_BIT);
        OP_XORI:  dec.control = onehot(ALU_XOR_BIT);
        OP_LUI:   dec.control = onehot(ALU_LUI_BIT);
        OP_LLI:   dec.control = onehot(ALU_LLI_BIT);
        default:  dec.illegal = 1'b1;
      endcase
    end
    // Undecodable entries still travel down the pipe, but carry no operands or target.
    if (dec.illegal) begin
      dec.control = '0;
      dec.src1    = '0;
      dec.src2    = '0;
      dec.wdest   = '0;
    end
  end

endmodule

// File: rtl/alu_op_issue.sv
// Issue stage: decode, output register plus one-entry skid buffer, saturating statistics.
module alu_op_issue
  import alu_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      inst,
  input  logic [31:0]      rs_value,
  input  logic [31:0]      rt_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      alu_control,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  output logic [4:0]       wdest,
  output logic             illegal,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [CNT_W-1:0] illegal_cnt
);

  issue_t dec;
  issue_t or_data_q, or_data_d;
  issue_t sk_data_q, sk_data_d;
  logic   or_valid_q, or_valid_d;
  logic   sk_valid_q, sk_valid_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] illegal_cnt_q, illegal_cnt_d;
  logic   accept;
  logic   out_fire;

  alu_op_decode u_decode (
    .inst     (inst),
    .rs_value (rs_value),
    .rt_value (rt_value),
    .dec      (dec)
  );

  assign accept   = in_valid & ~sk_valid_q;
  assign out_fire = or_valid_q & out_ready;

  always_comb begin
    or_valid_d    = or_valid_q;
    or_data_d     = or_data_q;
    sk_valid_d    = sk_valid_q;
    sk_data_d     = sk_data_q;
    issued_d      = issued_q;
    illegal_cnt_d = illegal_cnt_q;

    if (!or_valid_q || out_fire) begin
      if (sk_valid_q) begin
        or_valid_d = 1'b1;
        or_data_d  = sk_data_q;
        sk_valid_d = 1'b0;
      end else if (accept) begin
        or_valid_d = 1'b1;
        or_data_d  = dec;
      end else begin
        or_valid_d = 1'b0;
      end
    end else if (accept) begin
      sk_valid_d = 1'b1;
      sk_data_d  = dec;
    end

    // Flush only drops entries; the handshake already happening still counts below.
    if (flush) begin
      or_valid_d = 1'b0;
      sk_valid_d = 1'b0;
    end

    if (out_fire && issued_q != '1)
      issued_d = issued_q + CNT_W'(1);
    if (out_fire && or_data_q.illegal && illegal_cnt_q != '1)
      illegal_cnt_d = illegal_cnt_q + CNT_W'(1);
  end

  // NOTE: data registers are reset too, because the outputs must read zero out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      or_valid_q    <= 1'b0;
      or_data_q     <= '0;
      sk_valid_q    <= 1'b0;
      sk_data_q     <= '0;
      issued_q      <= '0;
      illegal_cnt_q <= '0;
    end else begin
      or_valid_q    <= or_valid_d;
      or_data_q     <= or_data_d;
      sk_valid_q    <= sk_valid_d;
      sk_data_q     <= sk_data_d;
      issued_q      <= issued_d;
      illegal_cnt_q <= illegal_cnt_d;
    end
  end

  assign in_ready    = ~sk_valid_q;
  assign out_valid   = or_valid_q;
  assign alu_control = or_data_q.control;
  assign alu_src1    = or_data_q.src1;
  assign alu_src2    = or_data_q.src2;
  assign wdest       = or_data_q.wdest;
  assign illegal     = or_data_q.illegal;
  assign issued_cnt  = issued_q;
  assign illegal_cnt = illegal_cnt_q;

endmodule

// File: tb/tb_alu_op_issue.sv
// Directed bench: decode vector table plus stall, flush, reset and saturation sequences.
module tb_alu_op_issue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  wdest;
  logic        illegal;
  logic [15:0] issued_cnt;
  logic [15:0] illegal_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  alu_op_issue #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .wdest       (wdest),
    .illegal     (illegal),
    .issued_cnt  (issued_cnt),
    .illegal_cnt (illegal_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [15:0] ctrl;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [4:0]  wd;
    logic        ill;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [4:0] sa,
                                       input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic add_vec(input logic [31:0] i_, input logic [31:0] r_, input logic [31:0] t_,
                         input logic [15:0] c_, input logic [31:0] a_, input logic [31:0] b_,
                         input logic [4:0] w_, input logic l_);
    vec_t v;
    v.inst = i_; v.rs = r_; v.rt = t_; v.ctrl = c_;
    v.s1 = a_; v.s2 = b_; v.wd = w_; v.ill = l_;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [31:0] i_, input logic [31:0] r_, input logic [31:0] t_);
    inst = i_; rs_value = r_; rt_value = t_;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " out_valid"},   32'(out_valid),   32'd0);
    check({tag, " in_ready"},    32'(in_ready),    32'd1);
    check({tag, " alu_control"}, 32'(alu_control), 32'd0);
    check({tag, " alu_src1"},    alu_src1,         32'd0);
    check({tag, " alu_src2"},    alu_src2,         32'd0);
    check({tag, " wdest"},       32'(wdest),       32'd0);
    check({tag, " illegal"},     32'(illegal),     32'd0);
    check({tag, " issued_cnt"},  32'(issued_cnt),  32'd0);
    check({tag, " illegal_cnt"}, 32'(illegal_cnt), 32'd0);
  endtask

  initial begin
    int n_ill;
    logic [15:0] cnt_before;
    logic [31:0] ill_word;

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    drive(32'd0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");

    // ---- decode table ----
    add_vec(i_op(6'b001001, 5'd3, 5'd5, 16'hFFFF), 32'd7, 32'h55, 16'h0800, 32'd7, 32'hFFFF_FFFF, 5'd5, 1'b0);
    add_vec(r_op(5'd0, 5'd1, 5'd2, 5'd4, 6'b000011), 32'h99, 32'h8000_0000, 16'h0002, 32'd4, 32'h8000_0000, 5'd2, 1'b0);
    add_vec(i_op(6'b011000, 5'd1, 5'd7, 16'h1234), 32'hAA, 32'h0, 16'h8000, 32'hAA, 32'h0000_1234, 5'd7, 1'b0);
    add_vec(r_op(5'd1, 5'd2, 5'd9, 5'd0, 6'b100010), 32'd10, 32'd3, 16'h0400, 32'd10, 32'd3, 5'd9, 1'b0);
    add_vec(r_op(5'd4, 5'd5, 5'd4, 5'd3, 6'b000111), 32'd5, 32'hF0, 16'h0002, 32'd5, 32'hF0, 5'd4, 1'b0);
    add_vec(i_op(6'b001100, 5'd2, 5'd6, 16'h8000), 32'd1, 32'd9, 16'h0080, 32'd1, 32'h0000_8000, 5'd6, 1'b0);
    add_vec(i_op(6'b001010, 5'd2, 5'd8, 16'h8000), 32'd2, 32'd9, 16'h0200, 32'd2, 32'hFFFF_8000, 5'd8, 1'b0);
    add_vec(r_op(5'd1, 5'd2, 5'd31, 5'd0, 6'b101000), 32'hF0F0, 32'h0FF0, 16'h4000, 32'hF0F0, 32'h0FF0, 5'd31, 1'b0);
    add_vec(32'hFFFF_FFFF, 32'd12, 32'd34, 16'h0000, 32'd0, 32'd0, 5'd0, 1'b1);
    add_vec(r_op(5'd1, 5'd2, 5'd12, 5'd0, 6'b101101), 32'd21, 32'd22, 16'h2000, 32'd21, 32'd22, 5'd12, 1'b0);
    add_vec(r_op(5'd1, 5'd2, 5'd13, 5'd0, 6'b101100), 32'd23, 32'd24, 16'h1000, 32'd23, 32'd24, 5'd13, 1'b0);
    add_vec(i_op(6'b001111, 5'd0, 5'd10, 16'hABCD), 32'd3, 32'd0, 16'h0001, 32'd3, 32'h0000_ABCD, 5'd10, 1'b0);
    add_vec(r_op(5'd0, 5'd3, 5'd11, 5'd31, 6'b000000), 32'h77, 32'd1, 16'h0008, 32'd31, 32'd1, 5'd11, 1'b0);
    add_vec(r_op(5'd0, 5'd3, 5'd13, 5'd1, 6'b000010), 32'h77, 32'h44, 16'h0004, 32'd1, 32'h44, 5'd13, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd14, 5'd0, 6'b100111), 32'h11, 32'h22, 16'h0040, 32'h11, 32'h22, 5'd14, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd15, 5'd0, 6'b100110), 32'h33, 32'h44, 16'h0010, 32'h33, 32'h44, 5'd15, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd16, 5'd0, 6'b100101), 32'h55, 32'h66, 16'h0020, 32'h55, 32'h66, 5'd16, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd17, 5'd0, 6'b101011), 32'h1, 32'h2, 16'h0100, 32'h1, 32'h2, 5'd17, 1'b0);
    add_vec(i_op(6'b001011, 5'd6, 5'd18, 16'h7FFF), 32'h3, 32'h4, 16'h0100, 32'h3, 32'h0000_7FFF, 5'd18, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd19, 5'd0, 6'b000001), 32'h5, 32'h6, 16'h0000, 32'd0, 32'd0, 5'd0, 1'b1);
    add_vec(r_op(5'd6, 5'd7, 5'd20, 5'd0, 6'b100001), 32'h7, 32'h8, 16'h0800, 32'h7, 32'h8, 5'd20, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd21, 5'd0, 6'b100100), 32'h9, 32'hA, 16'h0080, 32'h9, 32'hA, 5'd21, 1'b0);
    add_vec(i_op(6'b001101, 5'd6, 5'd22, 16'hF00F), 32'hB, 32'hC, 16'h0020, 32'hB, 32'h0000_F00F, 5'd22, 1'b0);
    add_vec(i_op(6'b001110, 5'd6, 5'd23, 16'h8001), 32'hD, 32'hE, 16'h0010, 32'hD, 32'h0000_8001, 5'd23, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd24, 5'd2, 6'b000100), 32'h4, 32'hF, 16'h0008, 32'h4, 32'hF, 5'd24, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd25, 5'd2, 6'b000110), 32'h6, 32'h10, 16'h0004, 32'h6, 32'h10, 5'd25, 1'b0);
    add_vec(r_op(5'd6, 5'd7, 5'd26, 5'd0, 6'b101010), 32'h12, 32'h13, 16'h0200, 32'h12, 32'h13, 5'd26, 1'b0);

    // One vector per cycle with out_ready high: each is visible exactly one cycle after acceptance.
    out_ready = 1'b1;
    n_ill = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      in_valid = 1'b1;
      drive(vecs[i].inst, vecs[i].rs, vecs[i].rt);
      if (vecs[i].ill) n_ill++;
      @(negedge clk);
      check($sformatf("v%0d out_valid", i), 32'(out_valid),   32'd1);
      check($sformatf("v%0d control", i),   32'(alu_control), 32'(vecs[i].ctrl));
      check($sformatf("v%0d src1", i),      alu_src1,         vecs[i].s1);
      check($sformatf("v%0d src2", i),      alu_src2,         vecs[i].s2);
      check($sformatf("v%0d wdest", i),     32'(wdest),       32'(vecs[i].wd));
      check($sformatf("v%0d illegal", i),   32'(illegal),     32'(vecs[i].ill));
      check($sformatf("v%0d in_ready", i),  32'(in_ready),    32'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("table drained out_valid", 32'(out_valid),   32'd0);
    check("table issued_cnt",        32'(issued_cnt),  32'(vecs.size()));
    check("table illegal_cnt",       32'(illegal_cnt), 32'(n_ill));

    // ---- reset while OR and SK both hold entries ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'h1, 32'h2);
    @(negedge clk);
    drive(r_op(5'd1, 5'd2, 5'd4, 5'd0, 6'b100000), 32'h3, 32'h4);
    @(negedge clk);
    in_valid = 1'b0;
    check("stall full in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst mid-stall");

    // ---- back-to-back three with consumer stalled two cycles ----
    in_valid = 1'b1;
    drive(r_op(5'd1, 5'd2, 5'd1, 5'd0, 6'b100000), 32'hA1, 32'hB1);
    @(negedge clk);
    check("b2b A out_valid", 32'(out_valid), 32'd1);
    check("b2b A in_ready",  32'(in_ready),  32'd1);
    drive(r_op(5'd1, 5'd2, 5'd2, 5'd0, 6'b100000), 32'hA2, 32'hB2);
    @(negedge clk);
    check("b2b in_ready drop", 32'(in_ready), 32'd0);
    check("b2b hold wdest 1",  32'(wdest),    32'd1);
    drive(r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'b100000), 32'hA3, 32'hB3);
    @(negedge clk);
    check("b2b still blocked", 32'(in_ready), 32'd0);
    check("b2b hold src1 A",   alu_src1,      32'hA1);
    out_ready = 1'b1;
    @(negedge clk);
    check("b2b B wdest",       32'(wdest),    32'd2);
    check("b2b B src1",        alu_src1,      32'hA2);
    check("b2b in_ready back", 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("b2b C wdest", 32'(wdest), 32'd3);
    check("b2b C src2",  alu_src2,   32'hB3);
    @(negedge clk);
    check("b2b drained",    32'(out_valid),  32'd0);
    check("b2b issued_cnt", 32'(issued_cnt), 32'd3);

    // ---- flush with OR and SK full ----
    out_ready = 1'b0;
    in_valid  = 1'b1;
    drive(r_op(5'd1, 5'd2, 5'd5, 5'd0, 6'b100100), 32'h5, 32'h6);
    @(negedge clk);
    drive(r_op(5'd1, 5'd2, 5'd6, 5'd0, 6'b100100), 32'h7, 32'h8);
    @(negedge clk);
    in_valid = 1'b0;
    check("flush pre in_ready", 32'(in_ready), 32'd0);
    cnt_before = issued_cnt;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush out_valid",   32'(out_valid),   32'd0);
    check("flush in_ready",    32'(in_ready),    32'd1);
    check("flush issued_cnt",  32'(issued_cnt),  32'(cnt_before));
    check("flush illegal_cnt", 32'(illegal_cnt), 32'd0);

    // Flush beats an acceptance in the same cycle.
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    check("flush vs accept out_valid", 32'(out_valid), 32'd0);

    // A handshake in the flush cycle still counts.
    in_valid = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush cycle handshake cnt", 32'(issued_cnt), 32'(cnt_before) + 32'd1);

    // ---- saturation: stream illegal words until both counters hit all-ones ----
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ill_word = 32'hFC00_0000;
    drive(ill_word, 32'd1, 32'd2);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int k = 0; k < 70000 && issued_cnt !== 16'hFFFF; k++) @(negedge clk);
    check("sat issued reached",  32'(issued_cnt),  32'h0000_FFFF);
    check("sat illegal reached", 32'(illegal_cnt), 32'h0000_FFFF);
    check("sat handshake live",  32'(out_valid & out_ready), 32'd1);
    @(negedge clk);
    check("sat issued hold",  32'(issued_cnt),  32'h0000_FFFF);
    check("sat illegal hold", 32'(illegal_cnt), 32'h0000_FFFF);
    in_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_op_issue.md
# alu_op_issue

Instruction-to-ALU issue stage: accepts a fetched 32-bit MIPS-style instruction plus its two register read values, decodes it into the 16-bit one-hot `alu_control` vector, the two ALU operands and the destination register, and presents them to the ALU through a registered valid/ready interface. It sits between register-file read and the ALU. It owns the producer end of the `alu_control`/`alu_src1`/`alu_src2` contract. Full throughput with a one-entry skid buffer, plus issue and illegal-instruction counters.

## Interface
- `CNT_W`, 16: width of the saturating statistics counters.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `flush`  in  1  synchronous; drops the output and skid entries.
- `in_valid`  in  1  instruction/operands valid.
- `in_ready`  out  1  registered; high when the skid entry is empty.
- `inst`  in  32  instruction word.
- `rs_value`, `rt_value`  in  32 each  register read data.
- `out_valid`  out  1  issue entry valid.
- `out_ready`  in  1  ALU/consumer accepts.
- `alu_control`  out  16  one-hot: [15]lli [14]nand [13]shtu [12]sht [11]add [10]sub [9]slt [8]sltu [7]and [6]nor [5]or [4]xor [3]sll [2]srl [1]sra [0]lui.
- `alu_src1`, `alu_src2`  out  32 each  ALU operands.
- `wdest`  out  5  destination register.
- `illegal`  out  1  entry is undecodable; `alu_control`=0 and `wdest`=0.
- `issued_cnt`, `illegal_cnt`  out  `CNT_W` each  saturating counters.

## Operation
- Decode, opcode 000000 (funct): sll 000000, srl 000010, sra 000011.
  - For these, src1={27'd0,inst[10:6]}, src2=rt_value.
  - sllv 000100, srlv 000110, srav 000111 use src1=rs_value.
  - add/addu 100000/100001→add; sub/subu 100010/100011→sub; and 100100; or 100101; xor 100110; nor 100111; nand 101000; slt 101010; sltu 101011; sht 101100; shtu 101101.
  - Non-shift R-type: src1=rs_value, src2=rt_value, wdest=inst[15:11].
- Decode, I-type: addiu 001001→add; slti 001010→slt; sltiu 001011→sltu. These use sign-extended imm.
  - andi 001100, ori 001101, xori 001110, lui 001111, lli 011000 use zero-extended imm.
  - src1=rs_value, src2=ext(imm), wdest=inst[20:16].
- Any other encoding sets `illegal`=1 with src1=src2=0. It is still issued so the pipeline sees it.
- Exactly one `alu_control` bit is set for every legal entry.
- Decoded fields are captured at acceptance (`in_valid & in_ready`). Operands are never re-sampled.
- Buffering, output register (OR) and skid register (SK):
  - Accept when OR is empty or is being consumed, and SK is empty → load OR.
  - Accept while OR is held (`out_valid & ~out_ready`) → load SK.
  - When OR is consumed and SK is full, SK moves to OR and SK empties.
  - `in_ready` = ~SK.valid.
- Counters:
  - `issued_cnt` increments on each output handshake (`out_valid & out_ready`).
  - `illegal_cnt` increments on each output handshake whose entry has `illegal`=1.
  - Both saturate at all-ones and are not cleared by `flush`.

## Timing
- Reset: `out_valid`=0, `in_ready`=1, `alu_control`=0, `alu_src1`=`alu_src2`=0, `wdest`=0, `illegal`=0, both counters 0.
- Latency: accepted in cycle N → `out_valid` in cycle N+1.
- Throughput: one per cycle while `out_ready`=1.
- Output data stays stable while `out_valid & ~out_ready`.
- SK full → `in_ready`=0 from the next cycle. It returns to 1 the cycle after SK drains into OR.
- `flush` clears OR and SK valid bits next cycle and wins over a same-cycle acceptance.
  - A handshake in the flush cycle still counts.
- `rst` has priority over `flush` and over all handshakes. Asserting it mid-stall discards both entries.
- When OR is consumed and a new acceptance occurs in the same cycle, the new entry loads directly into OR with no bubble.

## Structure
- Package `alu_ctrl_pkg` holds:
  - opcode and funct localparams;
  - one-hot bit-index constants (`ALU_ADD_BIT`=11, …);
  - a packed struct `issue_t` {control[15:0], src1, src2, wdest, illegal}.
- Sub-module `alu_op_decode`: purely combinational, inst/rs_value/rt_value → `issue_t`.
- The top level holds OR, SK and the counters.

## Test plan
- addiu rt=5, rs=3 (rs_value=7), imm=0xFFFF, out_ready=1 → next cycle `alu_control`=16'h0800, src1=7, src2=32'hFFFF_FFFF, wdest=5.
- sra rd=2, rt_value=32'h8000_0000, sa=4 → `alu_control`=16'h0002, src1=4, src2=32'h8000_0000, wdest=2; and lli imm=0x1234 → 16'h8000, src2=32'h0000_1234.
- Back-to-back 3 instructions with `out_ready` low for 2 cycles:
  - `in_ready` drops after the second accept;
  - outputs are delivered in order, none lost or duplicated;
  - `issued_cnt`=3.
- opcode 6'b111111 → `illegal`=1, `alu_control`=0, wdest=0, `illegal_cnt`=1.
- `flush` with OR and SK full → next cycle `out_valid`=0 and `in_ready`=1; counters unchanged.
- `rst` asserted while stalled → all outputs return to reset values in the next cycle. Force counters to 16'hFFFF → one more handshake leaves them at 16'hFFFF.
